dmem_arbiter: RTL

Two-core data-memory arbiter for the multi-core pipelined CPU. It sits between the MEM stages of core 0 and core 1 and the single shared data memory. It serializes their load/store requests with round-robin priority and a fixed-latency memory sequence. It stalls whichever core is waiting, which is how the pipeline's hazard/flush logic learns to hold the MEM stage.

---
 rtl/dmem_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-core data-memory arbiter: round-robin grant, fixed-latency access, per-core stall.
// Optional contention counters are built only when DMEM_ARB_PERF_EN is defined.
module dmem_arbiter #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              mem_read0_i,
  input  logic              mem_write0_i,
  input  logic [ADDR_W-1:0] addr0_i,
  input  logic [DATA_W-1:0] wdata0_i,
  output logic [DATA_W-1:0] rdata0_o,
  output logic              stall0_o,
  input  logic              mem_read1_i,
  input  logic              mem_write1_i,
  input  logic [ADDR_W-1:0] addr1_i,
  input  logic [DATA_W-1:0] wdata1_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic              stall1_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic [15:0]       conflict_cnt0_o,
  output logic [15:0]       conflict_cnt1_o
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [3:0] LatLast = 4'(MEM_LAT - 1);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              is_wr_q, is_wr_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic req0, req1, grant_core;
  logic st_idle, st_busy, st_done;

  assign req0 = mem_read0_i | mem_write0_i;
  assign req1 = mem_read1_i | mem_write1_i;
  // Tie goes to the core that did not win last time.
  assign grant_core = (req0 & req1) ? ~last_grant_q : req1;

  assign st_idle = (state_q == StIdle);
  assign st_busy = (state_q == StBusy);
  assign st_done = (state_q == StDone);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    is_wr_d      = is_wr_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (req0 | req1) begin
          owner_d      = grant_core;
          last_grant_d = grant_core;
          is_wr_d      = grant_core ? mem_write1_i : mem_write0_i;
          addr_d       = grant_core ? addr1_i : addr0_i;
          wdata_d      = grant_core ? wdata1_i : wdata0_i;
          cnt_d        = LatLast;
          state_d      = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q == 4'd0) begin
          if (!is_wr_q) rdata_d = mem_rdata_i;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      is_wr_q      <= 1'b0;
      cnt_q        <= 4'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      is_wr_q      <= is_wr_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
    end
  end

  // Write strobe only on the first BUSY cycle, where cnt still holds its load value.
  assign mem_en_o    = st_busy;
  assign mem_we_o    = st_busy & is_wr_q & (cnt_q == LatLast);
  assign mem_addr_o  = st_busy ? addr_q : '0;
  assign mem_wdata_o = st_busy ? wdata_q : '0;

  assign stall0_o = req0 & ~(st_done & ~owner_q);
  assign stall1_o = req1 & ~(st_done & owner_q);
  assign rdata0_o = owner_q ? '0 : rdata_q;
  assign rdata1_o = owner_q ? rdata_q : '0;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] cc0_q, cc0_d, cc1_q, cc1_d;
  logic        hit0, hit1;

  assign hit0 = stall0_o & ((~st_idle & owner_q) | (st_idle & req0 & req1 & grant_core));
  assign hit1 = stall1_o & ((~st_idle & ~owner_q) | (st_idle & req0 & req1 & ~grant_core));

  always_comb begin
    cc0_d = cc0_q;
    cc1_d = cc1_q;
    if (hit0 && (cc0_q != 16'hFFFF)) cc0_d = cc0_q + 16'd1;
    if (hit1 && (cc1_q != 16'hFFFF)) cc1_d = cc1_q + 16'd1;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      cc0_q <= 16'd0;
      cc1_q <= 16'd0;
    end else begin
      cc0_q <= cc0_d;
      cc1_q <= cc1_d;
    end
  end

  assign conflict_cnt0_o = cc0_q;
  assign conflict_cnt1_o = cc1_q;
`else
  assign conflict_cnt0_o = 16'd0;
  assign conflict_cnt1_o = 16'd0;
`endif

endmodule
